// File: rtl/my_aes_encipher_core.sv
// AES-128 encipher datapath driven by an external round-key streamer (my_aes_key_mem).
// One round per cycle; ciphertext is held in a one-entry valid/ready output register.

module aes_sbox (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  // Forward S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bit offset 8*(255-b) = {~b, 3'b000}
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign dout[8*i +: 8] = SBOX[{~din[8*i +: 8], 3'b000} +: 8];
  end
endmodule

module my_aes_encipher_core #(
  parameter logic [3:0] NUM_ROUNDS = 4'ha
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         km_init,
  output logic [127:0] km_key,
  input  logic [3:0]   km_round,
  input  logic [127:0] km_roundkey,
  input  logic         km_roundkey_valid,
  input  logic         km_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         error
);
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned RND_W   = 4;

  typedef enum logic [1:0] {IDLE, KINIT, WAITK, ROUND} state_t;

  state_t             state_q, state_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [BLOCK_W-1:0] km_key_d, out_block_d;
  logic               km_init_d, out_valid_d, error_d;
  logic [BLOCK_W-1:0] sub_bytes, shifted, mixed;
  logic               accept, pop;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  // Byte n = 4*col + row; row r rotates left by r columns
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   b0, b1, b2, b3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      b0 = s[127-32*c -: 8];
      b1 = s[119-32*c -: 8];
      b2 = s[111-32*c -: 8];
      b3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
      o[119-32*c -: 8] = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
      o[111-32*c -: 8] = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
      o[103-32*c -: 8] = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
    end
    return o;
  endfunction

  aes_sbox u_sbox (
    .din  (blk_q),
    .dout (sub_bytes)
  );

  assign shifted = shift_rows(sub_bytes);
  assign mixed   = mix_columns(shifted);

  // Accept only when the output slot is free or being popped this cycle
  assign in_ready = (state_q == IDLE) && km_ready && !error && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rnd_q     <= '0;
      blk_q     <= '0;
      km_key    <= '0;
      km_init   <= 1'b0;
      out_block <= '0;
      out_valid <= 1'b0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      blk_q     <= blk_d;
      km_key    <= km_key_d;
      km_init   <= km_init_d;
      out_block <= out_block_d;
      out_valid <= out_valid_d;
      error     <= error_d;
    end
  end

  // Next-state and datapath; a same-cycle result write overrides the pop
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    blk_d       = blk_q;
    km_key_d    = km_key;
    km_init_d   = 1'b0;
    out_block_d = out_block;
    out_valid_d = out_valid && !pop;
    error_d     = error;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          blk_d     = in_block;
          km_key_d  = in_key;
          km_init_d = 1'b1;
          state_d   = KINIT;
        end
      end
      KINIT: begin
        state_d = WAITK;
      end
      WAITK: begin
        if (km_roundkey_valid) begin
          if (km_round == '0) begin
            blk_d   = blk_q ^ km_roundkey;
            rnd_d   = RND_W'(1);
            state_d = ROUND;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      ROUND: begin
        if (!km_roundkey_valid || (km_round != rnd_q)) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (rnd_q == NUM_ROUNDS) begin
          out_block_d = shifted ^ km_roundkey;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          blk_d = mixed ^ km_roundkey;
          rnd_d = rnd_q + RND_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_my_aes_encipher_core.sv
// Bench for my_aes_encipher_core: acts as the key expander and compares ciphertexts
// against an AES-128 model built from GF(2^8) arithmetic.
`timescale 1ns/1ps
module tb_my_aes_encipher_core;
  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [127:0] in_key;
  logic         km_init;
  logic [127:0] km_key;
  logic [3:0]   km_round = 4'h0;
  logic [127:0] km_roundkey = '0;
  logic         km_roundkey_valid = 1'b0;
  logic         km_ready = 1'b1;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         error;

  my_aes_encipher_core #(.NUM_ROUNDS(4'ha)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_block          (in_block),
    .in_key            (in_key),
    .km_init           (km_init),
    .km_key            (km_key),
    .km_round          (km_round),
    .km_roundkey       (km_roundkey),
    .km_roundkey_valid (km_roundkey_valid),
    .km_ready          (km_ready),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_block         (out_block),
    .error             (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t         tbl [8];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           pop_cyc [$];
  logic [127:0] pop_blk [$];
  int           kinit_cyc [$];
  logic [7:0]   sbox_tab [256];
  logic [1407:0] exp_rk = '0;
  int           exp_idx = -1;
  int           drop_round = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  // S-box = affine(multiplicative inverse), inverse taken as x^254
  task automatic build_sbox();
    logic [7:0] inv, b, s;
    for (int v = 0; v < 256; v++) begin
      b = 8'(v);
      inv = 8'h00;
      if (v != 0) begin
        inv = b;
        for (int k = 0; k < 253; k++) inv = gmul(inv, b);
      end
      s = inv;
      b = inv;
      for (int k = 0; k < 4; k++) begin
        b = rotl1(b);
        s = s ^ b;
      end
      sbox_tab[v] = s ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) o[1407-32*i -: 32] = w[i];
    return o;
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key);
    logic [1407:0] ks;
    logic [7:0]    s [4][4];
    logic [7:0]    t [4][4];
    logic [7:0]    a0, a1, a2, a3;
    logic [127:0]  o;
    ks = expand(key);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ ks[1407-8*(4*c+r) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = sbox_tab[s[(r)][(c+r)%4]];
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[0][c]; a1 = s[1][c]; a2 = s[2][c]; a3 = s[3][c];
          s[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = s[r][c] ^ ks[1407-128*rnd-8*(4*c+r) -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  // ---------------- key expander stand-in ----------------
  // Round k is presented k+1 cycles after the km_init cycle; ready returns two cycles after round 10.
  always @(negedge clk) begin
    if (reset) begin
      exp_idx = -1;
      km_roundkey_valid = 1'b0;
      km_round = 4'h0;
      km_roundkey = '0;
      km_ready = 1'b1;
    end else begin
      if (exp_idx >= 0) begin
        if (exp_idx <= 10) begin
          km_roundkey_valid = (exp_idx != drop_round);
          km_round = 4'(exp_idx);
          km_roundkey = exp_rk[1407-128*exp_idx -: 128];
        end else begin
          km_roundkey_valid = 1'b0;
          if (exp_idx == 12) km_ready = 1'b1;
        end
        exp_idx = (exp_idx == 12) ? -1 : exp_idx + 1;
      end
      if (km_init) begin
        exp_rk = expand(km_key);
        exp_idx = 0;
        km_ready = 1'b0;
      end
    end
  end

  // Log pops and km_init pulses with the cycle they were seen in
  always @(negedge clk) begin
    #2;
    if (!reset && out_valid && out_ready) begin
      pop_cyc.push_back(cyc);
      pop_blk.push_back(out_block);
    end
    if (km_init) kinit_cyc.push_back(cyc);
  end

  // ---------------- checking helpers ----------------
  task automatic chk_blk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Offer a block until accepted; returns just after the accepting edge with in_valid still high
  task automatic offer(input logic [127:0] key, input logic [127:0] pt, output int t, output bit ok);
    ok = 1'b0;
    t = -1;
    @(negedge clk);
    in_valid = 1'b1;
    in_key = key;
    in_block = pt;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (in_ready) begin
        t = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
  endtask

  task automatic wait_pop(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #3;
      if (pop_cyc.size() > n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct, input string tag);
    int t, np, nk;
    bit ok;
    np = pop_cyc.size();
    nk = kinit_cyc.size();
    offer(key, pt, t, ok);
    chk_bit({tag, " accept"}, ok, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_blk({tag, " km_key"}, km_key, key);
    wait_pop(np, ok);
    chk_bit({tag, " out_valid seen"}, ok, 1'b1);
    if (ok) begin
      chk_int({tag, " latency"}, pop_cyc[np] - t, 13);
      chk_blk({tag, " ct"}, pop_blk[np], ct);
    end
    chk_int({tag, " km_init pulses"}, kinit_cyc.size() - nk, 1);
    if (kinit_cyc.size() > nk) chk_int({tag, " km_init cycle"}, kinit_cyc[nk] - t, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_bit({tag, " out_valid"}, out_valid, 1'b0);
    chk_blk({tag, " out_block"}, out_block, '0);
    chk_bit({tag, " error"}, error, 1'b0);
    chk_bit({tag, " km_init"}, km_init, 1'b0);
    chk_blk({tag, " km_key"}, km_key, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int  t1, t2, np;
    bit  ok1, ok2, got;

    reset = 1'b1;
    in_valid = 1'b0;
    in_block = '0;
    in_key = '0;
    out_ready = 1'b1;
    build_sbox();

    tbl[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, pt: 128'h00112233445566778899aabbccddeeff,
               ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tbl[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h3243f6a8885a308d313198a2e0370734,
               ct: 128'h3925841d02dc09fbdc118597196a0b32};
    for (int i = 2; i < 8; i++) begin
      tbl[i].key = {$urandom, $urandom, $urandom, $urandom};
      tbl[i].pt  = {$urandom, $urandom, $urandom, $urandom};
      tbl[i].ct  = aes_model(tbl[i].pt, tbl[i].key);
    end

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    #1;
    chk_bit("idle in_ready", in_ready, 1'b1);

    // Known-answer and random vectors, one at a time
    for (int i = 0; i < 8; i++) run_vec(tbl[i].key, tbl[i].pt, tbl[i].ct, $sformatf("vec%0d", i));

    // Back-to-back with in_valid held high and out_ready held 1
    np = pop_cyc.size();
    offer(tbl[2].key, tbl[2].pt, t1, ok1);
    offer(tbl[3].key, tbl[3].pt, t2, ok2);
    @(negedge clk);
    in_valid = 1'b0;
    wait_pop(np + 1, got);
    chk_bit("b2b accepts", ok1 && ok2, 1'b1);
    chk_int("b2b spacing", t2 - t1, 14);
    chk_bit("b2b pops", got, 1'b1);
    if (got) begin
      chk_int("b2b lat0", pop_cyc[np] - t1, 13);
      chk_blk("b2b ct0", pop_blk[np], tbl[2].ct);
      chk_int("b2b lat1", pop_cyc[np+1] - t2, 13);
      chk_blk("b2b ct1", pop_blk[np+1], tbl[3].ct);
    end

    // Backpressure: result held, next block refused until the pop
    @(negedge clk);
    out_ready = 1'b0;
    offer(tbl[0].key, tbl[0].pt, t1, ok1);
    chk_bit("bp accept", ok1, 1'b1);
    @(negedge clk);
    in_key = tbl[1].key;
    in_block = tbl[1].pt;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk_bit("bp out_valid", got, 1'b1);
    chk_int("bp latency", cyc - t1, 13);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk_bit($sformatf("bp hold%0d valid", i), out_valid, 1'b1);
      chk_blk($sformatf("bp hold%0d block", i), out_block, tbl[0].ct);
      chk_bit($sformatf("bp hold%0d in_ready", i), in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk_bit("bp in_ready on pop", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    chk_bit("bp popped", out_valid, 1'b0);
    np = pop_cyc.size();
    wait_pop(np, got);
    chk_bit("bp second pop", got, 1'b1);
    if (got) chk_blk("bp second ct", pop_blk[np], tbl[1].ct);

    // Key-stream fault: round 5 valid dropped
    np = pop_cyc.size();
    drop_round = 5;
    offer(tbl[4].key, tbl[4].pt, t1, ok1);
    chk_bit("fault accept", ok1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 2; i <= 30; i++) begin
      @(negedge clk);
      #1;
      if (i == 7) chk_bit("fault error before", error, 1'b0);
      if (i >= 8) begin
        chk_bit($sformatf("fault c%0d error", i), error, 1'b1);
        chk_bit($sformatf("fault c%0d in_ready", i), in_ready, 1'b0);
        chk_bit($sformatf("fault c%0d out_valid", i), out_valid, 1'b0);
      end
    end
    chk_int("fault no pop", pop_cyc.size(), np);
    drop_round = -1;

    // Reset mid-operation, then a clean vector
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("clear");
    offer(tbl[0].key, tbl[0].pt, t1, ok1);
    chk_bit("rst accept", ok1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_vec(tbl[1].key, tbl[1].pt, tbl[1].ct, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
